// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - sequential 16x16 shift-and-add multiplier (low 16 product bits)
//
// Add16: 16-bit ripple-carry adder used for every partial-product accumulation.
//   a_i, b_i [15:0] : addends
//   cin_i           : carry in
//   sum_o [15:0]    : a_i + b_i + cin_i (mod 2^16)
//   cout_o          : carry out of bit 15
//
// mul16_seq: multiply unit with valid/ready handshakes on both sides.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/in_ready, a, b   : operand handshake (in_ready high only in IDLE)
//   out_valid/out_ready, out  : result handshake (out_valid high only in DONE)
//   Latency from accept edge to out_valid is 16 edges; result is identical
//   for unsigned and two's-complement operands.

module Add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [16:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[16];

endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [15:0] sum;
  // Product bits above 15 are discarded, so the adder carry-out goes nowhere.
  logic        carry_unused;

  Add16 u_add16 (
    .a_i    (acc_q),
    .b_i    (mcand_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry_unused)
  );

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = acc_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = 16'h0000;
          cnt_d    = 4'd0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = sum;
        end
        // Always 16 iterations, even once the multiplier runs out of ones.
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      acc_q    <= 16'h0000;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - self-checking bench for mul16_seq

module tb_mul16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dut_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] sb[$];

  mul16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for the result (optionally stalling the consumer
  // and/or disturbing the operand inputs while busy), then retire it.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] exp, input int stall, input bit noise);
    int n;
    logic [15:0] got_exp;
    out_ready = (stall == 0);
    check({tag, "_in_ready_pre"}, in_ready, 1'b1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    step();                       // accept edge E
    sb.push_back(exp);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
      if (!out_valid && noise) begin
        a        = 16'($urandom);
        b        = 16'($urandom);
        in_valid = ~in_valid;
      end
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, n, 16);
    for (int i = 0; i < stall; i++) begin
      check({tag, "_stall_out"}, dut_out, exp);
      check({tag, "_stall_in_ready"}, in_ready, 1'b0);
      check({tag, "_stall_out_valid"}, out_valid, 1'b1);
      a        = 16'($urandom);
      b        = 16'($urandom);
      in_valid = i[0];
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_sb_nonempty"}, sb.size(), 1);
    if (sb.size() != 0) begin
      got_exp = sb.pop_front();
      check({tag, "_out"}, dut_out, got_exp);
    end
    check({tag, "_out_valid_hs"}, out_valid, 1'b1);
    step();                       // result handshake edge F
    check({tag, "_in_ready_post"}, in_ready, 1'b1);
    check({tag, "_out_valid_post"}, out_valid, 1'b0);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    logic [31:0] prod;
    logic [15:0] na, nb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", dut_out, 16'h0000);
    #10;
    rst_n = 1'b1;
    step();

    do_op("basic",   16'd3,     16'd5,     16'h000F, 0, 1'b0);
    do_op("ffff_sq", 16'hFFFF,  16'hFFFF,  16'h0001, 0, 1'b0);
    do_op("300_sq",  16'd300,   16'd300,   16'h5F90, 0, 1'b0);
    do_op("neg3x5",  16'hFFFD,  16'd5,     16'hFFF1, 0, 1'b0);
    do_op("by_zero", 16'h1234,  16'h0000,  16'h0000, 0, 1'b0);
    do_op("by_one",  16'h1234,  16'h0001,  16'h1234, 0, 1'b0);
    do_op("zero_x",  16'h0000,  16'hFFFF,  16'h0000, 0, 1'b0);
    do_op("bp7x9",   16'd7,     16'd9,     16'h003F, 5, 1'b0);

    na = 16'h0ABC;
    nb = 16'h0123;
    prod = 32'(na) * 32'(nb);
    do_op("busy_iso", na, nb, prod[15:0], 0, 1'b1);

    for (int k = 0; k < 3; k++) begin
      na = 16'($urandom);
      nb = 16'($urandom);
      prod = 32'(na) * 32'(nb);
      do_op("rand", na, nb, prod[15:0], k, 1'b0);
    end

    // Reset in the middle of an operation.
    out_ready = 1'b1;
    a         = 16'd100;
    b         = 16'd200;
    in_valid  = 1'b1;
    step();
    sb.push_back(16'd20000);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out", dut_out, 16'h0000);
    check("midrst_in_ready", in_ready, 1'b1);
    step();
    #2;
    rst_n = 1'b1;
    step();
    do_op("post_rst", 16'd2, 16'd8, 16'h0010, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
